omsp_spm_cmd_seq: RTL and testbench

Sequencer directly upstream of the SPM control stage. It takes a protect/unprotect request from the decode stage, latches the layout operands, and stalls the CPU while it runs. It drives the one-cycle update/enable strobe and the stable layout registers into the SPM array, then samples the array's violation and occupancy feedback. It returns a result word (new SPM ID, or 0 on failure) for write-back into r15.

---
 rtl/omsp_spm_cmd_seq.sv | 124 ++++++++++++
 tb/tb_omsp_spm_cmd_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/omsp_spm_cmd_seq.sv
// SPM protect/unprotect command sequencer.
// Latches layout operands, strobes the SPM array, returns an ID for r15.
module omsp_spm_cmd_seq #(
   parameter int ID_WIDTH = 16
) (
   input  logic                mclk,
   input  logic                puc_rst,
   input  logic                req_valid,
   input  logic                req_disable,
   input  logic [15:0]         r12_in,
   input  logic [15:0]         r13_in,
   input  logic [15:0]         r14_in,
   input  logic [15:0]         r15_in,
   input  logic                spm_violation,
   input  logic                spm_full,
   output logic                update_spm,
   output logic                enable_spm,
   output logic [15:0]         r12,
   output logic [15:0]         r13,
   output logic [15:0]         r14,
   output logic [15:0]         r15,
   output logic                cpu_stall,
   output logic                result_wr,
   output logic [ID_WIDTH-1:0] result_val
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      UPDATE,
      WAIT,
      DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_dis;
   logic                r_fail;
   logic [ID_WIDTH-1:0] r_id_cnt;
   logic [15:0]         r_r12;
   logic [15:0]         r_r13;
   logic [15:0]         r_r14;
   logic [15:0]         r_r15;
   logic                w_bad;
   logic                w_ok;

   assign w_bad = (r_r12 >= r_r13) | (r_r14 >= r_r15) | spm_full;
   assign w_ok  = ~r_dis & ~r_fail;

   always_comb begin
      w_next     = r_state;
      update_spm = 1'b0;
      enable_spm = 1'b0;
      result_wr  = 1'b0;
      result_val = '0;
      cpu_stall  = 1'b1;
      unique case (r_state)
         IDLE: begin
            cpu_stall = req_valid;
            if (req_valid)
               w_next = CHECK;
         end
         CHECK: begin
            if (~r_dis & w_bad)
               w_next = DONE;
            else
               w_next = UPDATE;
         end
         UPDATE: begin
            update_spm = 1'b1;
            enable_spm = ~r_dis;
            w_next     = WAIT;
         end
         WAIT: begin
            w_next = DONE;
         end
         DONE: begin
            result_wr = 1'b1;
            if (w_ok)
               result_val = r_id_cnt;
            w_next = IDLE;
         end
         default: begin
            cpu_stall = 1'b0;
            w_next    = IDLE;
         end
      endcase
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         r_state  <= IDLE;
         r_dis    <= 1'b0;
         r_fail   <= 1'b0;
         r_id_cnt <= ID_WIDTH'(1);
         r_r12    <= '0;
         r_r13    <= '0;
         r_r14    <= '0;
         r_r15    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && req_valid) begin
            r_dis <= req_disable;
            r_r12 <= r12_in;
            r_r13 <= r13_in;
            r_r14 <= r14_in;
            r_r15 <= r15_in;
         end
         if (r_state == CHECK)
            r_fail <= ~r_dis & w_bad;
         if (r_state == WAIT)
            r_fail <= spm_violation;
         // Zero is reserved as the failure code, so the counter skips it.
         if (r_state == DONE && w_ok)
            r_id_cnt <= (&r_id_cnt) ? ID_WIDTH'(1) : r_id_cnt + ID_WIDTH'(1);
      end
   end

   assign r12 = r_r12;
   assign r13 = r_r13;
   assign r14 = r_r14;
   assign r15 = r_r15;

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Bench for omsp_spm_cmd_seq: directed and random requests against
// a transaction-level model; a narrow-ID twin exercises counter wrap.
module tb_omsp_spm_cmd_seq;

   localparam int NB_SPMS = 4;

   logic        mclk = 1'b0;
   logic        puc_rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_disable = 1'b0;
   logic [15:0] r12_in = '0;
   logic [15:0] r13_in = '0;
   logic [15:0] r14_in = '0;
   logic [15:0] r15_in = '0;
   logic        spm_violation = 1'b0;
   logic        spm_full = 1'b0;

   logic        upd, en, stall, rwr;
   logic [15:0] o12, o13, o14, o15, rval;
   logic        upd3, en3, stall3, rwr3;
   logic [15:0] p12, p13, p14, p15;
   logic [2:0]  rval3;

   int checks = 0;
   int failures = 0;

   int unsigned    id16;
   int unsigned    id3;
   logic [15:0]    lat [4];

   always #5 mclk = ~mclk;

   omsp_spm_cmd_seq dut (
      .mclk(mclk), .puc_rst(puc_rst),
      .req_valid(req_valid), .req_disable(req_disable),
      .r12_in(r12_in), .r13_in(r13_in),
      .r14_in(r14_in), .r15_in(r15_in),
      .spm_violation(spm_violation), .spm_full(spm_full),
      .update_spm(upd), .enable_spm(en),
      .r12(o12), .r13(o13), .r14(o14), .r15(o15),
      .cpu_stall(stall), .result_wr(rwr), .result_val(rval)
   );

   omsp_spm_cmd_seq #(.ID_WIDTH(3)) dut3 (
      .mclk(mclk), .puc_rst(puc_rst),
      .req_valid(req_valid), .req_disable(req_disable),
      .r12_in(r12_in), .r13_in(r13_in),
      .r14_in(r14_in), .r15_in(r15_in),
      .spm_violation(spm_violation), .spm_full(spm_full),
      .update_spm(upd3), .enable_spm(en3),
      .r12(p12), .r13(p13), .r14(p14), .r15(p15),
      .cpu_stall(stall3), .result_wr(rwr3), .result_val(rval3)
   );

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, ".r12"}, o12, lat[0]);
      chk({tag, ".r13"}, o13, lat[1]);
      chk({tag, ".r14"}, o14, lat[2]);
      chk({tag, ".r15"}, o15, lat[3]);
   endtask

   task automatic model_reset();
      id16 = 1;
      id3  = 1;
      for (int i = 0; i < 4; i++) lat[i] = '0;
   endtask

   task automatic idle_cycle(input string tag);
      @(negedge mclk);
      req_valid     = 1'b0;
      req_disable   = 1'($urandom);
      r12_in        = 16'($urandom);
      r13_in        = 16'($urandom);
      r14_in        = 16'($urandom);
      r15_in        = 16'($urandom);
      spm_violation = 1'($urandom);
      spm_full      = 1'($urandom);
      #1;
      chk({tag, ".stall"}, 16'(stall), 16'd0);
      chk({tag, ".upd"}, 16'(upd), 16'd0);
      chk({tag, ".en"}, 16'(en), 16'd0);
      chk({tag, ".wr"}, 16'(rwr), 16'd0);
      chk({tag, ".val"}, rval, 16'd0);
      chk_regs(tag);
   endtask

   // One request issued at cycle k=0; abort>=0 asserts reset in that cycle.
   task automatic do_req(input string tag, input bit dis,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input bit full, input bit viol,
                         input int abort);
      bit          sane;
      bit          ok;
      int          upd_k;
      int          done_k;
      logic [15:0] e16;
      logic [15:0] e3;
      logic [15:0] nl [4];
      sane   = dis || !((a >= b) || (c >= d) || full);
      ok     = !dis && sane && !viol;
      upd_k  = sane ? 2 : -1;
      done_k = sane ? 4 : 2;
      e16    = ok ? 16'(id16) : 16'd0;
      e3     = ok ? 16'(id3) : 16'd0;
      nl[0] = a; nl[1] = b; nl[2] = c; nl[3] = d;
      for (int k = 0; k <= done_k; k++) begin
         @(negedge mclk);
         req_valid     = (k == 0);
         req_disable   = (k == 0) ? dis : 1'($urandom);
         r12_in        = (k == 0) ? a : 16'($urandom);
         r13_in        = (k == 0) ? b : 16'($urandom);
         r14_in        = (k == 0) ? c : 16'($urandom);
         r15_in        = (k == 0) ? d : 16'($urandom);
         spm_full      = (k == 1) ? full : 1'($urandom);
         spm_violation = (k == 3) ? viol : 1'($urandom);
         if (k == abort) begin
            req_valid = 1'b0;
            puc_rst   = 1'b1;
            model_reset();
            #1;
            chk({tag, ".rst.upd"}, 16'(upd), 16'd0);
            chk({tag, ".rst.en"}, 16'(en), 16'd0);
            chk({tag, ".rst.stall"}, 16'(stall), 16'd0);
            chk({tag, ".rst.wr"}, 16'(rwr), 16'd0);
            chk({tag, ".rst.val"}, rval, 16'd0);
            chk_regs({tag, ".rst"});
            @(negedge mclk);
            #1;
            chk({tag, ".rst2.wr"}, 16'(rwr), 16'd0);
            chk({tag, ".rst2.upd"}, 16'(upd), 16'd0);
            puc_rst = 1'b0;
            return;
         end
         if (k == 1)
            for (int i = 0; i < 4; i++) lat[i] = nl[i];
         #1;
         chk({tag, ".stall"}, 16'(stall), 16'd1);
         chk({tag, ".upd"}, 16'(upd), 16'(k == upd_k));
         chk({tag, ".en"}, 16'(en), 16'(k == upd_k && !dis));
         chk({tag, ".wr"}, 16'(rwr), 16'(k == done_k));
         chk({tag, ".val"}, rval, (k == done_k) ? e16 : 16'd0);
         chk({tag, ".val3"}, 16'(rval3), (k == done_k) ? e3 : 16'd0);
         chk({tag, ".wr3"}, 16'(rwr3), 16'(k == done_k));
         chk_regs(tag);
      end
      if (ok) begin
         id16 = (id16 == 16'hFFFF) ? 1 : id16 + 1;
         id3  = (id3 == 7) ? 1 : id3 + 1;
      end
      idle_cycle({tag, ".after"});
   endtask

   initial begin
      bit          dis, full, viol;
      logic [15:0] a, b, c, d;
      model_reset();
      repeat (2) @(negedge mclk);
      #1;
      chk("reset.stall", 16'(stall), 16'd0);
      chk("reset.upd", 16'(upd), 16'd0);
      chk("reset.wr", 16'(rwr), 16'd0);
      chk("reset.val", rval, 16'd0);
      chk_regs("reset");
      puc_rst = 1'b0;
      idle_cycle("idle0");

      do_req("badlay", 0, 16'h1100, 16'h1000, 16'h2000, 16'h2100, 0, 0, -1);
      do_req("ok1", 0, 16'h1000, 16'h1100, 16'h2000, 16'h2100, 0, 0, -1);
      do_req("ok2", 0, 16'h1000, 16'h1100, 16'h2000, 16'h2100, 0, 0, -1);
      do_req("viol", 0, 16'h1000, 16'h1100, 16'h2000, 16'h2100, 0, 1, -1);
      do_req("full", 0, 16'h1000, 16'h1100, 16'h2000, 16'h2100, 1, 0, -1);
      do_req("ok3", 0, 16'h3000, 16'h3100, 16'h4000, 16'h4100, 0, 0, -1);
      do_req("unprot", 1, 16'h1000, 16'h1100, 16'h2000, 16'h2100, 0, 0, -1);
      do_req("unprotv", 1, 16'h5000, 16'h0100, 16'h2000, 16'h2000, 1, 1, -1);
      do_req("eq12", 0, 16'h1000, 16'h1000, 16'h2000, 16'h2100, 0, 0, -1);
      do_req("eq14", 0, 16'h1000, 16'h1001, 16'h2100, 16'h2100, 0, 0, -1);
      do_req("abort", 0, 16'h1000, 16'h1100, 16'h2000, 16'h2100, 0, 0, 2);
      idle_cycle("postrst");
      do_req("okrst", 0, 16'h1000, 16'h1100, 16'h2000, 16'h2100, 0, 0, -1);
      for (int i = 0; i < 8; i++)
         do_req("wrap", 0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 0, 0, -1);

      for (int t = 0; t < 60; t++) begin
         dis  = ($urandom_range(0, 4) == 0);
         full = ($urandom_range(0, 5) == 0);
         viol = ($urandom_range(0, 5) == 0);
         a = 16'($urandom);
         c = 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            b = 16'($urandom);
            d = 16'($urandom);
         end else begin
            a = a >> 1;
            c = c >> 1;
            b = a + 16'($urandom_range(1, 16'h7FFF));
            d = c + 16'($urandom_range(1, 16'h7FFF));
         end
         do_req("rand", dis, a, b, c, d, full, viol, -1);
         repeat ($urandom_range(0, 2)) idle_cycle("gap");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench did not finish (NB_SPMS=%0d)", NB_SPMS);
   end

endmodule
